// File: rtl/dmem_burst_reader_if.sv
// Bus bundle for dmem_burst_reader: request channel, dmem block-address/data
// path and the word output stream. The slave modport is the reader's view;
// the master modport is the surrounding system's view.
interface dmem_burst_reader_if #(
  parameter int data_width = 32,
  parameter int addr_width = 15,
  parameter int cnt_width  = 16
);
  logic                    i_REQ_VALID;
  logic                    o_REQ_READY;
  logic [addr_width-1:0]   i_REQ_ADDR;
  logic [cnt_width-1:0]    i_REQ_COUNT;
  logic [addr_width-1:0]   o_MEM_ADDR;
  logic [16*data_width-1:0] i_MEM_RDATA;
  logic                    o_OUT_VALID;
  logic                    i_OUT_READY;
  logic [data_width-1:0]   o_OUT_DATA;
  logic                    o_OUT_LAST;

  modport slave (
    input  i_REQ_VALID, i_REQ_ADDR, i_REQ_COUNT, i_MEM_RDATA, i_OUT_READY,
    output o_REQ_READY, o_MEM_ADDR, o_OUT_VALID, o_OUT_DATA, o_OUT_LAST
  );

  modport master (
    output i_REQ_VALID, i_REQ_ADDR, i_REQ_COUNT, i_MEM_RDATA, i_OUT_READY,
    input  o_REQ_READY, o_MEM_ADDR, o_OUT_VALID, o_OUT_DATA, o_OUT_LAST
  );
endinterface

// File: rtl/dmem_burst_reader.sv
// dmem_burst_reader: fetches a burst of words from the 16-wide dmem one
// 16-word block at a time (ISSUE -> WAIT), buffers the block, then streams
// it out one word per valid/ready handshake (STREAM).
// Optional feature macro: DMEM_BURST_BOUNDS_EN -- when defined, requests that
// run past the top of the address space are rejected with a one-cycle o_ERR.
module dmem_burst_reader #(
  parameter int data_width = 32,
  parameter int addr_width = 15,
  parameter int cnt_width  = 16
) (
  input  logic                i_CLK,
  input  logic                i_RSTn,
  dmem_burst_reader_if.slave  bus,
  output logic                o_BUSY,
  output logic                o_ERR
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STREAM} state_t;

  state_t                state_reg, state_next;
  logic [addr_width-1:0] mem_addr_reg, mem_addr_next;
  logic [cnt_width-1:0]  remaining_reg, remaining_next;
  logic [3:0]            index_reg, index_next;
  logic [data_width-1:0] out_data_reg, out_data_next;
  logic                  out_last_reg, out_last_next;
  logic                  out_valid_reg;
  logic                  busy_reg;
  logic                  err_reg, err_next;
  logic [data_width-1:0] buffer_reg [16];
  logic                  buf_load;

  logic req_fire, req_nonzero, req_oob, out_fire;

  assign bus.o_REQ_READY = (state_reg == IDLE) && i_RSTn;
  assign req_fire        = bus.i_REQ_VALID && bus.o_REQ_READY;
  assign req_nonzero     = (bus.i_REQ_COUNT != '0);
  assign out_fire        = out_valid_reg && bus.i_OUT_READY;

`ifdef DMEM_BURST_BOUNDS_EN
  // One extra bit so that addr + count can exceed 2^addr_width without wrapping.
  localparam int sum_width = ((addr_width > cnt_width) ? addr_width : cnt_width) + 1;
  logic [sum_width-1:0] req_end;
  assign req_end = sum_width'(bus.i_REQ_ADDR) + sum_width'(bus.i_REQ_COUNT);
  assign req_oob = (req_end > (sum_width'(1) << addr_width));
`else
  assign req_oob = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (req_fire && req_nonzero && !req_oob) state_next = ISSUE;
      ISSUE:  state_next = WAIT;
      WAIT:   state_next = STREAM;
      STREAM: begin
        if (out_fire) begin
          if (remaining_reg == cnt_width'(1)) state_next = IDLE;
          else if (index_reg == 4'hF)         state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath/output next values; the registered outputs lead with the word
  // that will be presented in the following cycle.
  always_comb begin
    mem_addr_next  = mem_addr_reg;
    remaining_next = remaining_reg;
    index_next     = index_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    err_next       = 1'b0;
    buf_load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_fire) begin
          err_next = req_oob;
          if (req_nonzero && !req_oob) begin
            mem_addr_next  = bus.i_REQ_ADDR;
            remaining_next = bus.i_REQ_COUNT;
            index_next     = 4'd0;
          end
        end
      end
      WAIT: begin
        // Block arrives now; word 0 goes straight to the output register.
        buf_load      = 1'b1;
        out_data_next = bus.i_MEM_RDATA[data_width-1:0];
        out_last_next = (remaining_reg == cnt_width'(1));
      end
      STREAM: begin
        if (out_fire) begin
          remaining_next = remaining_reg - cnt_width'(1);
          index_next     = index_reg + 4'd1;
          out_data_next  = buffer_reg[index_reg + 4'd1];
          out_last_next  = (remaining_reg == cnt_width'(2));
          if (remaining_reg == cnt_width'(1)) begin
            out_last_next = 1'b0;
          end else if (index_reg == 4'hF) begin
            mem_addr_next = mem_addr_reg + addr_width'(16);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      mem_addr_reg  <= '0;
      remaining_reg <= '0;
      index_reg     <= '0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      mem_addr_reg  <= mem_addr_next;
      remaining_reg <= remaining_next;
      index_reg     <= index_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      out_valid_reg <= (state_next == STREAM);
      busy_reg      <= (state_next != IDLE);
      err_reg       <= err_next;
    end
  end

  // Block buffer: all 16 dmem words captured together at the end of WAIT.
  always_ff @(posedge i_CLK) begin
    if (buf_load && i_RSTn) begin
      for (int k = 0; k < 16; k++) begin
        buffer_reg[k] <= bus.i_MEM_RDATA[k*data_width +: data_width];
      end
    end
  end

  assign bus.o_MEM_ADDR  = mem_addr_reg;
  assign bus.o_OUT_VALID = out_valid_reg;
  assign bus.o_OUT_DATA  = out_data_reg;
  assign bus.o_OUT_LAST  = out_last_reg;
  assign o_BUSY          = busy_reg;
  assign o_ERR           = err_reg;

endmodule

// File: tb/tb_dmem_burst_reader.sv
// Self-checking bench for dmem_burst_reader with a behavioural dmem and a
// reference model: burst (base, n) must yield mem[(base+i) mod 2^15], i<n.
`timescale 1ns/1ps
module tb_dmem_burst_reader;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int CW = 16;
  localparam int MEM_WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;

  always #5 clk = ~clk;

  dmem_burst_reader_if #(.data_width(DW), .addr_width(AW), .cnt_width(CW)) bus();

  dmem_burst_reader #(.data_width(DW), .addr_width(AW), .cnt_width(CW)) dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus),
    .o_BUSY (busy),
    .o_ERR  (err)
  );

  // Behavioural dmem: registered 16-word read starting at the presented address.
  logic [DW-1:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++)
      bus.i_MEM_RDATA[k*DW +: DW] <= mem[AW'(bus.o_MEM_ADDR + AW'(k))];
  end

  int checks = 0;
  int errors = 0;

  // Observations collected by run_burst.
  logic [DW-1:0] got_data[$];
  bit            got_last[$];
  int            hs_cyc[$];
  logic [AW-1:0] addr_seq[$];
  int            stable_viol;
  int            first_valid_k;
  bit            tmo;

  function automatic logic [DW-1:0] ref_word(input int base, input int i);
    return mem[(base + i) % MEM_WORDS];
  endfunction

  // Issue a request from the current negedge and collect the output stream.
  // rmode: 0 ready always high, 1 toggling 1,0,1..., 2 random.
  task automatic run_burst(input int a, input int c, input int rmode, input int abort_after);
    int k;
    int guard;
    logic [DW-1:0] prev_d;
    bit prev_l;
    bit prev_stall;
    got_data.delete(); got_last.delete(); hs_cyc.delete(); addr_seq.delete();
    stable_viol = 0; first_valid_k = -1; tmo = 1'b0;
    prev_d = '0; prev_l = 1'b0; prev_stall = 1'b0;
    bus.i_REQ_ADDR  = AW'(a);
    bus.i_REQ_COUNT = CW'(c);
    bus.i_REQ_VALID = 1'b1;
    guard = 0;
    while (!bus.o_REQ_READY && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.o_REQ_READY) begin
      tmo = 1'b1;
      bus.i_REQ_VALID = 1'b0;
      return;
    end
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      bus.i_REQ_VALID = 1'b0;
      case (rmode)
        0:       bus.i_OUT_READY = 1'b1;
        1:       bus.i_OUT_READY = k[0];
        default: bus.i_OUT_READY = 1'($urandom_range(0, 1));
      endcase
      if (addr_seq.size() == 0 || addr_seq[addr_seq.size()-1] != bus.o_MEM_ADDR)
        addr_seq.push_back(bus.o_MEM_ADDR);
      if (bus.o_OUT_VALID) begin
        if (first_valid_k < 0) first_valid_k = k;
        if (prev_stall && (bus.o_OUT_DATA !== prev_d || bus.o_OUT_LAST !== prev_l))
          stable_viol++;
        prev_stall = !bus.i_OUT_READY;
        prev_d = bus.o_OUT_DATA;
        prev_l = bus.o_OUT_LAST;
        if (bus.i_OUT_READY) begin
          got_data.push_back(bus.o_OUT_DATA);
          got_last.push_back(bus.o_OUT_LAST);
          hs_cyc.push_back(k);
          if (got_data.size() == c || bus.o_OUT_LAST) break;
          if (abort_after > 0 && got_data.size() == abort_after) break;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (k > 60 + 4 * c) begin
        tmo = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_REQ_VALID = 1'b1;
    bus.i_REQ_ADDR  = 15'h0055;
    bus.i_REQ_COUNT = 16'd3;
    bus.i_OUT_READY = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.o_OUT_VALID, bus.o_OUT_LAST, busy, err, bus.o_REQ_READY} !== 5'b0) begin
        errors++;
        $display("FAIL reset_flags: got %b expected 00000", {bus.o_OUT_VALID, bus.o_OUT_LAST, busy, err, bus.o_REQ_READY});
      end
      checks++;
      if (bus.o_MEM_ADDR !== '0 || bus.o_OUT_DATA !== '0) begin
        errors++;
        $display("FAIL reset_regs: got addr %h data %h expected 0 0", bus.o_MEM_ADDR, bus.o_OUT_DATA);
      end
    end
    rst_n = 1'b1;
    bus.i_REQ_VALID = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_REQ_READY !== 1'b1 || busy !== 1'b0 || bus.o_MEM_ADDR !== '0) begin
      errors++;
      $display("FAIL reset_release: got ready %b busy %b addr %h expected 1 0 0", bus.o_REQ_READY, busy, bus.o_MEM_ADDR);
    end
  endtask

  task automatic test_short();
    run_burst(32'h10, 5, 0, 0);
    checks++;
    if (tmo !== 1'b0 || got_data.size() !== 5) begin
      errors++;
      $display("FAIL short_count: got %0d words (timeout %b) expected 5", got_data.size(), tmo);
    end
    checks++;
    if (addr_seq.size() < 1 || addr_seq[0] !== 15'h0010) begin
      errors++;
      $display("FAIL short_mem_addr: got %h expected 0010", (addr_seq.size() > 0) ? addr_seq[0] : 15'h7FFF);
    end
    checks++;
    if (first_valid_k !== 3) begin
      errors++;
      $display("FAIL short_latency: got %0d expected 3", first_valid_k);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ref_word(32'h10, i) || got_last[i] !== (i == 4) || hs_cyc[i] !== 3 + i) begin
        errors++;
        $display("FAIL short_word[%0d]: got %h last %b cyc %0d expected %h last %b cyc %0d",
                 i, got_data[i], got_last[i], hs_cyc[i], ref_word(32'h10, i), (i == 4), 3 + i);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.o_REQ_READY !== 1'b1 || bus.o_OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL short_after: got ready %b valid %b expected 1 0", bus.o_REQ_READY, bus.o_OUT_VALID);
    end
  endtask

  task automatic test_multi_block();
    run_burst(32'h100, 40, 0, 0);
    checks++;
    if (tmo !== 1'b0 || got_data.size() !== 40) begin
      errors++;
      $display("FAIL multi_count: got %0d words (timeout %b) expected 40", got_data.size(), tmo);
    end
    checks++;
    if (addr_seq.size() !== 3 || addr_seq[0] !== 15'h0100 || addr_seq[1] !== 15'h0110 || addr_seq[2] !== 15'h0120) begin
      errors++;
      $display("FAIL multi_addr_steps: got %0d steps first %h expected 0100,0110,0120", addr_seq.size(),
               (addr_seq.size() > 0) ? addr_seq[0] : 15'h7FFF);
    end
    if (got_data.size() == 40) begin
      checks++;
      if (hs_cyc[16] - hs_cyc[15] !== 3 || hs_cyc[32] - hs_cyc[31] !== 3 || hs_cyc[15] - hs_cyc[14] !== 1) begin
        errors++;
        $display("FAIL multi_gaps: got %0d %0d %0d expected 3 3 1", hs_cyc[16] - hs_cyc[15],
                 hs_cyc[32] - hs_cyc[31], hs_cyc[15] - hs_cyc[14]);
      end
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ref_word(32'h100, i) || got_last[i] !== (i == 39)) begin
        errors++;
        $display("FAIL multi_word[%0d]: got %h last %b expected %h last %b",
                 i, got_data[i], got_last[i], ref_word(32'h100, i), (i == 39));
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = int'($urandom_range(0, MEM_WORDS - 20));
    @(negedge clk);
    run_burst(base, 20, 1, 0);
    checks++;
    if (tmo !== 1'b0 || got_data.size() !== 20 || stable_viol !== 0) begin
      errors++;
      $display("FAIL bp_stream: got %0d words, %0d unstable, timeout %b expected 20 0 0",
               got_data.size(), stable_viol, tmo);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ref_word(base, i) || got_last[i] !== (i == 19)) begin
        errors++;
        $display("FAIL bp_word[%0d]: got %h last %b expected %h last %b",
                 i, got_data[i], got_last[i], ref_word(base, i), (i == 19));
      end
    end
  endtask

  task automatic test_zero_count();
    int bad;
    @(negedge clk);
    bus.i_OUT_READY = 1'b1;
    bus.i_REQ_ADDR  = 15'h0123;
    bus.i_REQ_COUNT = 16'd0;
    bus.i_REQ_VALID = 1'b1;
    @(negedge clk);
    bus.i_REQ_VALID = 1'b0;
    bad = 0;
    repeat (6) begin
      if (bus.o_OUT_VALID !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || bus.o_REQ_READY !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL zero_count: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_boundary();
`ifdef DMEM_BURST_BOUNDS_EN
    int bad;
    @(negedge clk);
    bus.i_REQ_ADDR  = 15'h7FF8;
    bus.i_REQ_COUNT = 16'd16;
    bus.i_REQ_VALID = 1'b1;
    @(negedge clk);
    bus.i_REQ_VALID = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bounds_err: got err %b busy %b expected 1 0", err, busy);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (err !== 1'b0 || bus.o_OUT_VALID !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bounds_quiet: got %0d bad cycles expected 0", bad);
    end
`else
    @(negedge clk);
    run_burst(32'h7FF8, 16, 0, 0);
    checks++;
    if (tmo !== 1'b0 || got_data.size() !== 16 || err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_count: got %0d words err %b expected 16 0", got_data.size(), err);
    end
    if (got_data.size() == 16) begin
      checks++;
      if (got_data[7] !== mem[32'h7FFF] || got_data[8] !== mem[0] || got_data[15] !== mem[7]) begin
        errors++;
        $display("FAIL wrap_edge: got %h %h %h expected %h %h %h", got_data[7], got_data[8], got_data[15],
                 mem[32'h7FFF], mem[0], mem[7]);
      end
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ref_word(32'h7FF8, i) || got_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL wrap_word[%0d]: got %h expected %h", i, got_data[i], ref_word(32'h7FF8, i));
      end
    end
`endif
    // Exactly reaching the top of memory is legal in both builds.
    @(negedge clk);
    run_burst(32'h7FF0, 16, 0, 0);
    checks++;
    if (tmo !== 1'b0 || got_data.size() !== 16) begin
      errors++;
      $display("FAIL top_count: got %0d words expected 16", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ref_word(32'h7FF0, i)) begin
        errors++;
        $display("FAIL top_word[%0d]: got %h expected %h", i, got_data[i], ref_word(32'h7FF0, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = int'($urandom_range(0, 1000));
    @(negedge clk);
    run_burst(base, 10, 0, 3);
    checks++;
    if (got_data.size() !== 3 || got_data[0] !== ref_word(base, 0) || got_data[2] !== ref_word(base, 2)) begin
      errors++;
      $display("FAIL midrst_prefix: got %0d words expected 3 matching", got_data.size());
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_OUT_VALID !== 1'b0 || busy !== 1'b0 || bus.o_REQ_READY !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got valid %b busy %b ready %b expected 0 0 0",
               bus.o_OUT_VALID, busy, bus.o_REQ_READY);
    end
    rst_n = 1'b1;
    run_burst(32'h200, 2, 0, 0);
    checks++;
    if (tmo !== 1'b0 || got_data.size() !== 2) begin
      errors++;
      $display("FAIL midrst_count: got %0d words expected 2", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ref_word(32'h200, i) || got_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL midrst_word[%0d]: got %h last %b expected %h last %b",
                 i, got_data[i], got_last[i], ref_word(32'h200, i), (i == 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int base;
    @(negedge clk);
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 40));
      base = int'($urandom_range(0, MEM_WORDS - n));
      run_burst(base, n, 2, 0);
      checks++;
      if (tmo !== 1'b0 || got_data.size() !== n || stable_viol !== 0) begin
        errors++;
        $display("FAIL b2b_stream[%0d]: got %0d words unstable %0d expected %0d 0", t, got_data.size(), stable_viol, n);
      end
      for (int i = 0; i < got_data.size(); i++) begin
        checks++;
        if (got_data[i] !== ref_word(base, i) || got_last[i] !== (i == n - 1)) begin
          errors++;
          $display("FAIL b2b_word[%0d.%0d]: got %h last %b expected %h last %b",
                   t, i, got_data[i], got_last[i], ref_word(base, i), (i == n - 1));
        end
      end
      @(negedge clk);
      checks++;
      if (bus.o_REQ_READY !== 1'b1 || bus.o_OUT_VALID !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got ready %b valid %b expected 1 0", t, bus.o_REQ_READY, bus.o_OUT_VALID);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    bus.i_REQ_VALID = 1'b0;
    bus.i_REQ_ADDR  = '0;
    bus.i_REQ_COUNT = '0;
    bus.i_OUT_READY = 1'b0;
    test_reset();
    test_short();
    test_multi_block();
    test_backpressure();
    test_zero_count();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_burst_reader.md
# dmem_burst_reader

Burst-read sequencer that sits directly downstream of the 16-wide data memory `dmem`. It accepts a (base address, word count) request. It drives `dmem`'s address port one 16-word block at a time and captures each block in a local buffer. It then streams the words out one per handshake on a valid/ready interface to the consuming pipeline stage.

## Interface
- `data_width`, default 32: word width; must match `dmem`.
- `addr_width`, default 15: word-address width; must match `dmem`.
- `cnt_width`, default 16: request word-count width.

- `i_CLK`  in  1  clock; same net as `dmem` `i_CLKa`.
- `i_RSTn`  in  1  reset, synchronous, active-low.
- `i_REQ_VALID`  in  1  request valid.
- `o_REQ_READY`  out  1  request ready. High only in IDLE with `i_RSTn` high.
- `i_REQ_ADDR`  in  `addr_width`  first word address.
- `i_REQ_COUNT`  in  `cnt_width`  number of words to read.
- `o_MEM_ADDR`  out  `addr_width`  block address to `dmem` `i_ADDR`.
- `i_MEM_RDATA`  in  16*`data_width`  `dmem` outputs packed. Word k (`o_RDATAa` = 0 … `o_RDATAp` = 15) is at bits [k*`data_width` +: `data_width`].
- `o_OUT_VALID`  out  1  output word valid.
- `i_OUT_READY`  in  1  consumer ready.
- `o_OUT_DATA`  out  `data_width`  output word.
- `o_OUT_LAST`  out  1  marks the final word of the burst.
- `o_BUSY`  out  1  high in any state other than IDLE.
- `o_ERR`  out  1  one-cycle pulse on a rejected request. Tied 0 unless configured (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT, STREAM.
- IDLE:
  - Request accepted on `i_REQ_VALID & o_REQ_READY`.
  - Count 0: accepted, no output produced, remain in IDLE.
  - Otherwise: latch addr into `o_MEM_ADDR`, latch count into remaining counter, word index ← 0, go to ISSUE.
- ISSUE:
  - `o_MEM_ADDR` is stable; `dmem` registers it at the closing edge.
  - Go to WAIT.
- WAIT:
  - `i_MEM_RDATA` is valid.
  - Capture all 16 words into the buffer at the closing edge.
  - Go to STREAM.
- STREAM:
  - `o_OUT_VALID` = 1, `o_OUT_DATA` = buffer[index].
  - `o_OUT_LAST` = (remaining == 1).
  - On a handshake: index++, remaining--.
  - If that handshake consumed the last word: go to IDLE.
  - Else if index was 15: `o_MEM_ADDR` += 16, index ← 0, go to ISSUE.
- Backpressure: while `o_OUT_VALID & !i_OUT_READY`, the data, LAST and index hold unchanged. No word is dropped or duplicated.
- Address arithmetic is modulo 2^`addr_width` and wraps silently, consistent with `dmem`'s own `+k` indexing.
- Remaining counter is `cnt_width` bits; maximum burst is 2^`cnt_width`−1 words.
- Reset mid-burst aborts the burst. The FSM goes to IDLE and the buffered words are discarded.

## Timing
- Reset values:
  - FSM = IDLE.
  - `o_MEM_ADDR`, `o_OUT_DATA`, index and remaining = 0.
  - `o_OUT_VALID`, `o_OUT_LAST`, `o_BUSY`, `o_ERR` = 0.
  - `o_REQ_READY` = 0 while `i_RSTn` low; 1 in the first cycle after release.
- Latency:
  - Accept at edge E0.
  - ISSUE spans E0–E1; WAIT spans E1–E2.
  - First `o_OUT_VALID` appears in the cycle after E2, i.e. 3 cycles from the accept edge.
- With `i_OUT_READY` held high:
  - One word per cycle within a block.
  - 2-cycle bubble (ISSUE + WAIT) between blocks.
- `o_REQ_READY` returns high the cycle after the LAST handshake. Back-to-back requests therefore have one idle cycle between them.
- All outputs are registered except `o_REQ_READY`, which is decoded from state and `i_RSTn`.

## Configuration
- Macro: `DMEM_BURST_BOUNDS_EN`.
- Defined: a request with `i_REQ_ADDR` + `i_REQ_COUNT` > 2^`addr_width` is handled as follows:
  - It is accepted but rejected.
  - `o_ERR` pulses high for exactly 1 cycle after the accept edge.
  - No memory access or output occurs; the FSM stays in IDLE.
- Not defined: no check is made, addresses wrap, and `o_ERR` is constant 0.

## Test plan
- Reset behaviour: `i_RSTn` low for 2 cycles with `i_REQ_VALID`=1.
  - All outputs are 0 during reset.
  - `o_REQ_READY`=1 the cycle after release.
  - No request is accepted during reset.
- Short burst: addr 0x0010, count 5, `i_OUT_READY`=1.
  - `o_MEM_ADDR`=0x0010.
  - Output is mem[0x10..0x14] on 5 consecutive cycles, starting 3 cycles after accept.
  - LAST is asserted only on the 5th word.
- Multi-block burst: addr 0x0100, count 40.
  - `o_MEM_ADDR` steps 0x0100 → 0x0110 → 0x0120.
  - A 2-cycle valid gap occurs after words 16 and 32.
  - LAST is asserted on word 40.
- Backpressure: count 20 with `i_OUT_READY` toggling 1,0,1,0…
  - Output is the exact sequence mem[base..base+19], held stable across ready-low cycles.
- Zero count and boundary: count 0 produces no `o_OUT_VALID` and the FSM stays in IDLE. Addr 0x7FF8, count 16:
  - Macro undefined: output is mem[0x7FF8..0x7FFF] followed by mem[0x0000..0x0007].
  - Macro defined: `o_ERR` pulses for 1 cycle, with no output.
- Reset mid-stream: assert reset after 3 words of a count-10 burst.
  - `o_OUT_VALID`=0 from the reset edge.
  - A new request (addr 0x0200, count 2) then completes correctly.
